flash_insn_fetch: RTL and testbench
===================================

Name: flash_insn_fetch

Overview:
- Upstream stage feeding the Gigatron CPU instruction bus.
- Converts a 16-bit ROM word address into two byte reads from the 8-bit parallel flash and assembles the 16-bit instruction, low byte first.
- Presents the instruction with a level ready flag; the clock-stretch logic uses that flag to hold the cycle before clk1.
- Replaces the ad-hoc rom_counter sequencing in the top level with a timed, parameterised fetcher and an optional word cache.

Parameters:
- WAIT_CYCLES, 4: CLOCK_50 cycles per byte access after the address becomes valid. Legal range 1..15; any other value is an elaboration error.
- BASE_ADDR, 22'h000000: flash byte offset of ROM word 0.
- CACHE_AW, 6: log2 of cache entries. Used only with the cache feature.

Ports:
- CLOCK_50  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  one-cycle fetch request.
- romaddr  in  16  word address; sampled only when req is accepted.
- cache_flush  in  1  invalidates all cache entries. Ignored without the cache feature.
- insn  out  16  assembled instruction.
- insn_rdy  out  1  level signal: insn is valid for the last accepted romaddr.
- busy  out  1  flash access in progress.
- FL_ADDR  out  22  flash byte address.
- FL_DQ  in  8  flash data.
- FL_CE_N, FL_OE_N  out  1  each  chip enable and output enable.
- FL_WE_N  out  1  write enable; constant 1.
- FL_RST_N  out  1  flash reset.

Behaviour:
- Reset (asynchronous): state IDLE; insn=0, insn_rdy=0, busy=0, FL_ADDR=0, wait counter=0, FL_RST_N=0.
  - FL_RST_N is registered and goes to 1 on the first clock edge after reset_n deasserts.
  - FL_CE_N=0 and FL_OE_N=0 whenever reset_n=1; both are 1 while in reset.
- States: IDLE, RD_LO, RD_HI, DONE.
- IDLE or DONE with req=1 (edge T):
  - latch romaddr;
  - FL_ADDR <= BASE_ADDR + {romaddr,1'b0};
  - insn_rdy <= 0, busy <= 1;
  - counter <= WAIT_CYCLES; go to RD_LO.
- RD_LO: decrement the counter each edge. On the edge where counter==1:
  - insn[7:0] <= FL_DQ;
  - FL_ADDR[0] <= 1;
  - counter <= WAIT_CYCLES; go to RD_HI.
- RD_HI: on the edge where counter==1:
  - insn[15:8] <= FL_DQ;
  - insn_rdy <= 1, busy <= 0;
  - FL_ADDR <= 0; go to DONE.
- Latency: req accepted at edge T gives insn_rdy=1 after edge T+2*WAIT_CYCLES. WAIT_CYCLES=4 means 8 cycles, 160 ns.
- DONE: insn and insn_rdy hold until the next accepted req. They are unaffected by romaddr changes without req.
- req while busy=1: ignored; no queueing. The requester must wait for insn_rdy.
- FL_ADDR arithmetic: 22-bit, modulo 2^22. No saturation.
- reset_n asserted mid-fetch: immediate return to reset values. A partial word is never presented.

Optional Feature:
- Macro: FLASH_CACHE_EN.
- Defined: direct-mapped cache of 2^CACHE_AW words.
  - Index romaddr[CACHE_AW-1:0]; tag romaddr[15:CACHE_AW]; one valid bit per entry.
  - All valid bits are cleared by reset and by cache_flush.
  - Hit on accepted req: insn and insn_rdy=1 after edge T+1; no flash cycle; busy stays 0.
  - Miss: normal fetch; the entry is written on the RD_HI completion edge.
  - cache_flush together with req: flush applies first, so the req is a miss.
  - cache_flush during a fetch: the in-flight fill is discarded and the entry is left invalid.
- Undefined: no storage; cache_flush is unused; every req takes the flash path.

Decomposition:
- Shared package gigatron_pkg:
  - fetch state enum;
  - ROM_WORD_W=16, FLASH_AW=22, FLASH_DW=8;
  - default WAIT_CYCLES constant.
- One natural sub-module: insn_cache. Holds the tag/valid/data arrays and the hit compare, and is instantiated only under FLASH_CACHE_EN.

Test Plan:
1. Flash model preloaded with bytes 0x34 at 0x000000 and 0x12 at 0x000001; WAIT_CYCLES=4; req with romaddr=0x0000 -> FL_ADDR=0x000000 then 0x000001; insn=0x1234; insn_rdy=1 exactly 8 edges after req.
2. BASE_ADDR=0x020000; req with romaddr=0xFFFF -> FL_ADDR=0x03FFFE then 0x03FFFF; flash bytes 0xCD at 0x03FFFE and 0xAB at 0x03FFFF -> insn=0xABCD.
3. Extra req pulses 3 cycles into a fetch with romaddr=0x0002 -> ignored; completed insn is the first address's word; busy falls together with the insn_rdy rise.
4. reset_n pulled low 5 cycles into a fetch -> insn=0, insn_rdy=0 and FL_ADDR=0 immediately; FL_RST_N=1 one edge after release; next req fetches correctly.
5. FLASH_CACHE_EN, CACHE_AW=6: fetch 0x0040, then re-request 0x0040 -> second insn_rdy after 1 edge with no FL_ADDR activity; request 0x0080, which has the same index and a different tag -> full 8-cycle fetch.
6. FLASH_CACHE_EN: cache_flush together with req for cached 0x0040 -> treated as a miss; 8-cycle fetch and correct insn.

Source files
------------

// File: rtl/gigatron_pkg.sv
// Shared types and constants for the Gigatron flash instruction fetch path.
package gigatron_pkg;

  localparam int ROM_WORD_W      = 16;
  localparam int FLASH_AW        = 22;
  localparam int FLASH_DW        = 8;
  localparam int WAIT_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_DONE
  } fetch_state_e;

  // Byte address of the low byte of a ROM word; wraps modulo 2^FLASH_AW.
  function automatic logic [FLASH_AW-1:0] word_to_byte(input logic [FLASH_AW-1:0]   base,
                                                       input logic [ROM_WORD_W-1:0] waddr);
    return base + {{(FLASH_AW-ROM_WORD_W-1){1'b0}}, waddr, 1'b0};
  endfunction

endpackage

// File: rtl/insn_cache.sv
// Direct-mapped instruction word cache; built only when FLASH_CACHE_EN is defined.
`ifdef FLASH_CACHE_EN
module insn_cache
  import gigatron_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [ROM_WORD_W-1:0] lookup_addr,
  input  logic                  fill_start,
  input  logic                  fill_done,
  input  logic [ROM_WORD_W-1:0] fill_data,
  output logic                  hit,
  output logic [ROM_WORD_W-1:0] hit_data
);

  localparam int N  = 1 << AW;
  localparam int TW = ROM_WORD_W - AW;

  logic [N-1:0]            valid_q, valid_d;
  logic [TW-1:0]           tag_mem  [N];
  logic [ROM_WORD_W-1:0]   data_mem [N];
  logic [ROM_WORD_W-1:0]   fill_addr_q, fill_addr_d;
  logic                    kill_q, kill_d;
  logic                    wr_en;
  logic [AW-1:0]           lk_idx, wr_idx;

  assign lk_idx   = lookup_addr[AW-1:0];
  assign wr_idx   = fill_addr_q[AW-1:0];
  assign hit      = valid_q[lk_idx] && (tag_mem[lk_idx] == lookup_addr[ROM_WORD_W-1:AW]);
  assign hit_data = data_mem[lk_idx];

  // A flush seen while a fill is in flight poisons that fill.
  assign wr_en = fill_done && !kill_q && !flush;

  always_comb begin
    fill_addr_d = fill_start ? lookup_addr : fill_addr_q;
    kill_d      = fill_start ? 1'b0 : (flush ? 1'b1 : kill_q);
    valid_d     = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      fill_addr_q <= '0;
      kill_q      <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      fill_addr_q <= fill_addr_d;
      kill_q      <= kill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= fill_addr_q[ROM_WORD_W-1:AW];
      data_mem[wr_idx] <= fill_data;
    end
  end

endmodule
`endif

// File: rtl/flash_insn_fetch.sv
// Two-byte flash fetcher assembling 16-bit Gigatron instructions, low byte first.
// Optional word cache enabled by defining FLASH_CACHE_EN.
//   state    | meaning
//   ST_IDLE  | no word fetched since reset
//   ST_RD_LO | timing low-byte read
//   ST_RD_HI | timing high-byte read
//   ST_DONE  | insn valid (or cache hit pending), waiting for next req
module flash_insn_fetch
  import gigatron_pkg::*;
#(
  parameter int                  WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [FLASH_AW-1:0] BASE_ADDR   = '0,
  parameter int                  CACHE_AW    = 6
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic [ROM_WORD_W-1:0] romaddr,
  input  logic                  cache_flush,
  output logic [ROM_WORD_W-1:0] insn,
  output logic                  insn_rdy,
  output logic                  busy,
  output logic [FLASH_AW-1:0]   FL_ADDR,
  input  logic [FLASH_DW-1:0]   FL_DQ,
  output logic                  FL_CE_N,
  output logic                  FL_OE_N,
  output logic                  FL_WE_N,
  output logic                  FL_RST_N
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_range
    $error("flash_insn_fetch: WAIT_CYCLES must be within 1..15");
  end

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  fetch_state_e          state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ROM_WORD_W-1:0] insn_q, insn_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic [FLASH_AW-1:0]   addr_q, addr_d;
  logic                  hit_pend_q, hit_pend_d;
  logic                  fl_rst_n_q;
  logic                  fill_start, fill_done;
  logic                  cache_hit;
  logic [ROM_WORD_W-1:0] cache_data;

`ifdef FLASH_CACHE_EN
  logic                  lk_hit;
  logic [ROM_WORD_W-1:0] lk_data;

  insn_cache #(
    .AW(CACHE_AW)
  ) u_insn_cache (
    .clk         (CLOCK_50),
    .rst_n       (reset_n),
    .flush       (cache_flush),
    .lookup_addr (romaddr),
    .fill_start  (fill_start),
    .fill_done   (fill_done),
    .fill_data   ({FL_DQ, insn_q[7:0]}),
    .hit         (lk_hit),
    .hit_data    (lk_data)
  );

  // Flush takes effect before the lookup of a simultaneous request.
  assign cache_hit  = lk_hit && !cache_flush;
  assign cache_data = lk_data;
`else
  localparam int unused_cache_aw = CACHE_AW;
  logic unused_cache;
  assign unused_cache = ^{cache_flush, fill_start, fill_done};
  assign cache_hit    = 1'b0;
  assign cache_data   = '0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    insn_d     = insn_q;
    rdy_d      = rdy_q;
    busy_d     = busy_q;
    addr_d     = addr_q;
    hit_pend_d = 1'b0;
    fill_start = 1'b0;
    fill_done  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          rdy_d = 1'b0;
          if (cache_hit) begin
            insn_d     = cache_data;
            hit_pend_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            addr_d     = word_to_byte(BASE_ADDR, romaddr);
            busy_d     = 1'b1;
            cnt_d      = WAIT_LD;
            fill_start = 1'b1;
            state_d    = ST_RD_LO;
          end
        end else if (hit_pend_q) begin
          rdy_d = 1'b1;
        end
      end
      ST_RD_LO: begin
        if (cnt_q == 4'd1) begin
          insn_d[7:0] = FL_DQ;
          addr_d[0]   = 1'b1;
          cnt_d       = WAIT_LD;
          state_d     = ST_RD_HI;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RD_HI: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          insn_d[15:8] = FL_DQ;
          rdy_d        = 1'b1;
          busy_d       = 1'b0;
          addr_d       = '0;
          fill_done    = 1'b1;
          state_d      = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      insn_q     <= '0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      hit_pend_q <= 1'b0;
      fl_rst_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      insn_q     <= insn_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      hit_pend_q <= hit_pend_d;
      fl_rst_n_q <= 1'b1;
    end
  end

  assign insn     = insn_q;
  assign insn_rdy = rdy_q;
  assign busy     = busy_q;
  assign FL_ADDR  = addr_q;
  assign FL_CE_N  = ~reset_n;
  assign FL_OE_N  = ~reset_n;
  assign FL_WE_N  = 1'b1;
  assign FL_RST_N = fl_rst_n_q;

endmodule

// File: tb/tb_flash_insn_fetch.sv
// Directed plus randomized bench for flash_insn_fetch against a word-level flash/cache model.
module tb_flash_insn_fetch;

  localparam logic [21:0] BASE0 = 22'h000000;
  localparam logic [21:0] BASE1 = 22'h020000;
  localparam int          WAITC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] romaddr = '0;

  logic [15:0] insn0, insn1;
  logic        rdy0, rdy1, busy0, busy1;
  logic [21:0] fa0, fa1;
  logic [7:0]  dq0, dq1;
  logic        ce0, oe0, we0, frst0, ce1, oe1, we1, frst1;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  function automatic logic [7:0] fb(input logic [21:0] a);
    case (a)
      22'h000000: return 8'h34;
      22'h000001: return 8'h12;
      22'h03FFFE: return 8'hCD;
      22'h03FFFF: return 8'hAB;
      default:    return (a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]}) + 8'h5A;
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input logic [21:0] base, input logic [15:0] a);
    logic [21:0] b;
    b = base + {5'b0, a, 1'b0};
    return {fb(b + 22'd1), fb(b)};
  endfunction

  assign dq0 = fb(fa0);
  assign dq1 = fb(fa1);

  flash_insn_fetch #(.WAIT_CYCLES(WAITC), .BASE_ADDR(BASE0), .CACHE_AW(6)) u_dut0 (
    .CLOCK_50(clk), .reset_n(rst_n), .req(req), .romaddr(romaddr), .cache_flush(flush),
    .insn(insn0), .insn_rdy(rdy0), .busy(busy0), .FL_ADDR(fa0), .FL_DQ(dq0),
    .FL_CE_N(ce0), .FL_OE_N(oe0), .FL_WE_N(we0), .FL_RST_N(frst0));

  flash_insn_fetch #(.WAIT_CYCLES(WAITC), .BASE_ADDR(BASE1), .CACHE_AW(6)) u_dut1 (
    .CLOCK_50(clk), .reset_n(rst_n), .req(req), .romaddr(romaddr), .cache_flush(flush),
    .insn(insn1), .insn_rdy(rdy1), .busy(busy1), .FL_ADDR(fa1), .FL_DQ(dq1),
    .FL_CE_N(ce1), .FL_OE_N(oe1), .FL_WE_N(we1), .FL_RST_N(frst1));

`ifdef FLASH_CACHE_EN
  bit          mvalid [64];
  logic [9:0]  mtag   [64];
`endif

  task automatic model_reset();
`ifdef FLASH_CACHE_EN
    foreach (mvalid[i]) mvalid[i] = 1'b0;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request; extra=1 pulses a second req with romaddr=0x0002 three cycles in.
  task automatic fetch(input logic [15:0] a, input bit fl, input bit extra, input string tag);
    bit          hit;
    int          lat;
    logic        prev_busy;
    logic [21:0] lo0, lo1;
    hit = 1'b0;
`ifdef FLASH_CACHE_EN
    if (fl) model_reset();
    hit = mvalid[a[5:0]] && (mtag[a[5:0]] == a[15:6]);
`endif
    lo0 = BASE0 + {5'b0, a, 1'b0};
    lo1 = BASE1 + {5'b0, a, 1'b0};
    @(negedge clk);
    req = 1'b1; romaddr = a; flush = fl;
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b0;
    chk({tag, ".rdy_T"},  32'(rdy0),  32'(0));
    chk({tag, ".busy_T"}, 32'(busy0), 32'(!hit));
    chk({tag, ".addr0_T"}, 32'(fa0), hit ? 32'(0) : 32'(lo0));
    chk({tag, ".addr1_T"}, 32'(fa1), hit ? 32'(0) : 32'(lo1));
    lat = 0;
    prev_busy = busy0;
    for (int n = 1; n <= 40; n++) begin
      if (extra && n == 3) begin
        req = 1'b1; romaddr = 16'h0002;
      end
      @(posedge clk); #1;
      if (extra && n == 3) req = 1'b0;
      if (n == 4 && !hit) begin
        chk({tag, ".addr0_hi"}, 32'(fa0), 32'(lo0 + 22'd1));
        chk({tag, ".addr1_hi"}, 32'(fa1), 32'(lo1 + 22'd1));
      end
      if (rdy0) begin
        lat = n;
        break;
      end
      prev_busy = busy0;
    end
    chk({tag, ".latency"},   32'(lat), hit ? 32'(1) : 32'(2 * WAITC));
    chk({tag, ".insn0"},     32'(insn0), 32'(exp_word(BASE0, a)));
    chk({tag, ".insn1"},     32'(insn1), 32'(exp_word(BASE1, a)));
    chk({tag, ".rdy1"},      32'(rdy1), 32'(1));
    chk({tag, ".busy_end"},  32'(busy0), 32'(0));
    chk({tag, ".busy_prev"}, 32'(prev_busy), 32'(!hit));
    chk({tag, ".addr_end"},  32'(fa0), 32'(0));
`ifdef FLASH_CACHE_EN
    if (!hit) begin
      mvalid[a[5:0]] = 1'b1;
      mtag[a[5:0]]   = a[15:6];
    end
`endif
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] ra;
    bit          rfl;
    model_reset();
    #15;
    chk("rst.insn",  32'(insn0), 32'(0));
    chk("rst.rdy",   32'(rdy0),  32'(0));
    chk("rst.busy",  32'(busy0), 32'(0));
    chk("rst.addr",  32'(fa0),   32'(0));
    chk("rst.flrst", 32'(frst0), 32'(0));
    chk("rst.ce",    32'(ce0),   32'(1));
    chk("rst.oe",    32'(oe0),   32'(1));
    chk("rst.we",    32'(we0),   32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.ce",    32'(ce0),   32'(0));
    chk("rel.oe",    32'(oe1),   32'(0));
    chk("rel.flrst_pre", 32'(frst0), 32'(0));
    @(posedge clk); #1;
    chk("rel.flrst", 32'(frst0), 32'(1));

    fetch(16'h0000, 1'b0, 1'b0, "t1");
    fetch(16'hFFFF, 1'b0, 1'b0, "t2");
    chk("t2.insn_abcd", 32'(insn1), 32'h0000ABCD);

    fetch(16'h0007, 1'b0, 1'b1, "t3");
    repeat (3) @(posedge clk);
    #1;
    romaddr = 16'h1111;
    @(posedge clk); #1;
    chk("t3.hold_insn", 32'(insn0), 32'(exp_word(BASE0, 16'h0007)));
    chk("t3.hold_rdy",  32'(rdy0),  32'(1));

    @(negedge clk);
    req = 1'b1; romaddr = 16'h1234;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t4.insn",  32'(insn0), 32'(0));
    chk("t4.rdy",   32'(rdy0),  32'(0));
    chk("t4.addr",  32'(fa0),   32'(0));
    chk("t4.busy",  32'(busy0), 32'(0));
    chk("t4.flrst", 32'(frst0), 32'(0));
    chk("t4.ce",    32'(ce0),   32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t4.flrst_rel", 32'(frst0), 32'(1));
    fetch(16'h1234, 1'b0, 1'b0, "t4b");

    fetch(16'h0040, 1'b0, 1'b0, "t5a");
    fetch(16'h0040, 1'b0, 1'b0, "t5b");
    fetch(16'h0040, 1'b1, 1'b0, "t6");
    fetch(16'h0080, 1'b0, 1'b0, "t5c");
    fetch(16'h0080, 1'b0, 1'b0, "t5d");

    prev = 16'h0080;
    for (int i = 0; i < 20; i++) begin
      ra  = ($urandom_range(0, 2) == 0) ? prev : 16'($urandom);
      rfl = ($urandom_range(0, 5) == 0);
      fetch(ra, rfl, 1'b0, "rnd");
      prev = ra;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
